eth_mode_ctrl: RTL and testbench

Sequencer that generates the 3-bit `ctl` mode code steering the shared Ethernet-chip bus multiplexers: it decides which sub-controller (init, transmit-init, transmit, receive-init, receive) owns the bus. It starts each sub-controller, waits for its `done`, arbitrates transmit versus receive requests, and recovers from hung sub-controllers through a watchdog that forces re-initialisation. It sits between the host/FireWire-side packet logic and the bus multiplexers.

---
 rtl/eth_ctl_pkg.sv | 40 ++++
 rtl/eth_watchdog.sv | 44 ++++
 rtl/eth_mode_ctrl.sv | 161 ++++++++++++++++
 tb/tb_eth_mode_ctrl.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_ctl_pkg.sv
// Shared mode codes for the Ethernet-chip bus sequencer and the bus multiplexers it steers.
// Latency: n/a (constants and a pure decode function).
// Backpressure: n/a.
//
// Contents: eth_mode_e (the 3-bit ctl code), watchdog defaults, start-pulse decode.
package eth_ctl_pkg;

    // These values are decoded directly by the bus multiplexers, so they are fixed.
    typedef enum logic [2:0] {
        MODE_INIT   = 3'b000,
        MODE_TXINIT = 3'b001,
        MODE_TX     = 3'b010,
        MODE_RXINIT = 3'b011,
        MODE_RX     = 3'b100,
        MODE_IDLE   = 3'b111
    } eth_mode_e;

    // 1 ms at 49.152 MHz.
    localparam int unsigned TIMEOUT_DEFAULT = 49152;
    localparam int unsigned TO_W_DEFAULT    = 16;

    // Start pulse vector bit order: {rx, rxinit, tx, txinit, init}.
    localparam int unsigned START_W = 5;

    // One-hot start pulse for entry into mode m; Idle has no sub-controller to start.
    function automatic logic [START_W-1:0] mode_start(input eth_mode_e m);
        logic [START_W-1:0] s;
        s = '0;
        case (m)
            MODE_INIT:   s = 5'b00001;
            MODE_TXINIT: s = 5'b00010;
            MODE_TX:     s = 5'b00100;
            MODE_RXINIT: s = 5'b01000;
            MODE_RX:     s = 5'b10000;
            default:     s = 5'b00000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/eth_watchdog.sv
// Per-state watchdog: counts cycles spent in a non-Idle state, flags when the limit is reached.
// Latency: expired_o is a compare on the registered count (count == TIMEOUT-1).
// Backpressure: none; clr_i has priority over en_i, count saturates at TIMEOUT-1.
//
// Ports: sysclk, reset (async active-low), clr_i (state change), en_i (count this cycle),
//        expired_o (limit reached).
module eth_watchdog
    import eth_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = TO_W_DEFAULT
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] ONE   = TO_W'(1);

    logic [TO_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/eth_mode_ctrl.sv
// Bus-ownership sequencer: drives the ctl mode code, starts sub-controllers, arbitrates TX/RX.
// Latency: done or request in cycle n -> new ctl plus start pulse in cycle n+1; all outputs registered.
// Backpressure: tx_req is held by the host until tx_ack; irq_n held low until serviced.
//
// Ports: sysclk, reset (async active-low); tx_req, irq_n, *_done pulses, err_clr in;
//        ctl, *_start pulses, tx_ack, busy, err_timeout, err_state out.
module eth_mode_ctrl
    import eth_ctl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = TO_W_DEFAULT
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       tx_req,
    input  logic       irq_n,
    input  logic       init_done,
    input  logic       txinit_done,
    input  logic       tx_done,
    input  logic       rxinit_done,
    input  logic       rx_done,
    input  logic       err_clr,
    output logic [2:0] ctl,
    output logic       init_start,
    output logic       txinit_start,
    output logic       tx_start,
    output logic       rxinit_start,
    output logic       rx_start,
    output logic       tx_ack,
    output logic       busy,
    output logic       err_timeout,
    output logic [2:0] err_state
);

    eth_mode_e          ctl_q, ctl_d;
    logic [START_W-1:0] start_q, start_d;
    logic               boot_q;
    logic               last_rx_q, last_rx_d;
    logic               tx_ack_q, tx_ack_d;
    logic               busy_q, busy_d;
    logic               err_to_q, err_to_d;
    logic [2:0]         err_state_q, err_state_d;

    logic               done_sel;
    logic               done_ok;
    logic               trans;
    logic               wd_en;
    logic               wd_expired;

    // Only the done belonging to the current mode counts.
    always_comb begin
        done_sel = 1'b0;
        case (ctl_q)
            MODE_INIT:   done_sel = init_done;
            MODE_TXINIT: done_sel = txinit_done;
            MODE_TX:     done_sel = tx_done;
            MODE_RXINIT: done_sel = rxinit_done;
            MODE_RX:     done_sel = rx_done;
            default:     done_sel = 1'b0;
        endcase
    end

    // A start pulse marks the entry cycle; a done seen there cannot be a reply to this start.
    assign done_ok = done_sel && !boot_q && (start_q == '0);

    always_comb begin
        ctl_d       = ctl_q;
        trans       = 1'b0;
        tx_ack_d    = 1'b0;
        last_rx_d   = last_rx_q;
        err_to_d    = err_to_q && !err_clr;
        err_state_d = err_state_q;

        if (boot_q) begin
            // First edge after reset release: enter Init for real.
            ctl_d = MODE_INIT;
            trans = 1'b1;
        end else if (ctl_q == MODE_IDLE) begin
            // Receive wins unless it was served last and a transmit is also waiting.
            if (!irq_n && (!tx_req || !last_rx_q)) begin
                ctl_d     = MODE_RXINIT;
                trans     = 1'b1;
                last_rx_d = 1'b1;
            end else if (tx_req) begin
                ctl_d     = MODE_TXINIT;
                trans     = 1'b1;
                last_rx_d = 1'b0;
            end
        end else if (done_ok) begin
            // Done takes priority over a same-cycle watchdog expiry.
            trans = 1'b1;
            case (ctl_q)
                MODE_INIT:   ctl_d = MODE_IDLE;
                MODE_TXINIT: ctl_d = MODE_TX;
                MODE_TX: begin
                    ctl_d    = MODE_IDLE;
                    tx_ack_d = 1'b1;
                end
                MODE_RXINIT: ctl_d = MODE_RX;
                MODE_RX:     ctl_d = MODE_IDLE;
                default:     ctl_d = MODE_INIT;
            endcase
        end else if (wd_expired) begin
            // Hung sub-controller (or hung Init): re-initialise the chip.
            ctl_d       = MODE_INIT;
            trans       = 1'b1;
            err_to_d    = 1'b1;
            err_state_d = ctl_q;
        end

        start_d = trans ? mode_start(ctl_d) : '0;
        busy_d  = (ctl_d != MODE_IDLE);
    end

    assign wd_en = (ctl_q != MODE_IDLE);

    eth_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_watchdog (
        .sysclk    (sysclk),
        .reset     (reset),
        .clr_i     (trans),
        .en_i      (wd_en),
        .expired_o (wd_expired)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            ctl_q       <= MODE_INIT;
            start_q     <= '0;
            boot_q      <= 1'b1;
            last_rx_q   <= 1'b0;
            tx_ack_q    <= 1'b0;
            busy_q      <= 1'b1;
            err_to_q    <= 1'b0;
            err_state_q <= 3'b000;
        end else begin
            ctl_q       <= ctl_d;
            start_q     <= start_d;
            boot_q      <= 1'b0;
            last_rx_q   <= last_rx_d;
            tx_ack_q    <= tx_ack_d;
            busy_q      <= busy_d;
            err_to_q    <= err_to_d;
            err_state_q <= err_state_d;
        end
    end

    assign ctl          = ctl_q;
    assign init_start   = start_q[0];
    assign txinit_start = start_q[1];
    assign tx_start     = start_q[2];
    assign rxinit_start = start_q[3];
    assign rx_start     = start_q[4];
    assign tx_ack       = tx_ack_q;
    assign busy         = busy_q;
    assign err_timeout  = err_to_q;
    assign err_state    = err_state_q;

endmodule

// File: tb/tb_eth_mode_ctrl.sv
// Self-checking bench for eth_mode_ctrl with a short watchdog (TIMEOUT=16).
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
// Expected values come from the mode rules held in the bench (served order, phase lengths).
`timescale 1ns/1ps
module tb_eth_mode_ctrl;

    localparam int unsigned TO = 16;
    localparam logic [2:0] M_INIT = 3'b000;
    localparam logic [2:0] M_TXI  = 3'b001;
    localparam logic [2:0] M_TX   = 3'b010;
    localparam logic [2:0] M_RXI  = 3'b011;
    localparam logic [2:0] M_RX   = 3'b100;
    localparam logic [2:0] M_IDLE = 3'b111;

    logic       sysclk = 1'b0;
    logic       reset = 1'b0;
    logic       tx_req = 1'b0;
    logic       irq_n = 1'b1;
    logic       init_done = 1'b0, txinit_done = 1'b0, tx_done = 1'b0;
    logic       rxinit_done = 1'b0, rx_done = 1'b0, err_clr = 1'b0;
    logic [2:0] ctl, err_state;
    logic       init_start, txinit_start, tx_start, rxinit_start, rx_start;
    logic       tx_ack, busy, err_timeout;
    logic [9:0] obs;

    int   checks = 0;
    int   errors = 0;
    logic m_last_rx = 1'b0;

    always #5 sysclk = ~sysclk;

    eth_mode_ctrl #(.TIMEOUT(TO), .TO_W(5)) dut (
        .sysclk       (sysclk),
        .reset        (reset),
        .tx_req       (tx_req),
        .irq_n        (irq_n),
        .init_done    (init_done),
        .txinit_done  (txinit_done),
        .tx_done      (tx_done),
        .rxinit_done  (rxinit_done),
        .rx_done      (rx_done),
        .err_clr      (err_clr),
        .ctl          (ctl),
        .init_start   (init_start),
        .txinit_start (txinit_start),
        .tx_start     (tx_start),
        .rxinit_start (rxinit_start),
        .rx_start     (rx_start),
        .tx_ack       (tx_ack),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_state    (err_state)
    );

    assign obs = {ctl, busy, rx_start, rxinit_start, tx_start, txinit_start, init_start, tx_ack};

    // Expected {ctl, busy, starts, tx_ack} for mode m; st = this is the entry cycle.
    function automatic logic [9:0] expv(input logic [2:0] m, input logic st, input logic ack);
        logic [4:0] s;
        s = 5'b0;
        if (st) begin
            case (m)
                M_INIT:  s = 5'b00001;
                M_TXI:   s = 5'b00010;
                M_TX:    s = 5'b00100;
                M_RXI:   s = 5'b01000;
                M_RX:    s = 5'b10000;
                default: s = 5'b00000;
            endcase
        end
        return {m, (m != M_IDLE), s, ack};
    endfunction

    // Advance one cycle; one-cycle input pulses are withdrawn automatically.
    task automatic tick;
        @(posedge sysclk);
        #1;
        init_done = 1'b0; txinit_done = 1'b0; tx_done = 1'b0;
        rxinit_done = 1'b0; rx_done = 1'b0; err_clr = 1'b0;
    endtask

    task automatic pulse_done(input logic [2:0] m);
        case (m)
            M_INIT:  init_done = 1'b1;
            M_TXI:   txinit_done = 1'b1;
            M_TX:    tx_done = 1'b1;
            M_RXI:   rxinit_done = 1'b1;
            M_RX:    rx_done = 1'b1;
            default: ;
        endcase
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_INIT, 1'b0, 1'b0), 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", {obs, err_timeout, err_state},
                     {expv(M_INIT, 1'b0, 1'b0), 1'b0, 3'b000});
        end
        reset = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_INIT, 1'b1, 1'b0)) begin
            errors++; $display("FAIL reset_c1_start: got %b want %b", obs, expv(M_INIT, 1'b1, 1'b0));
        end
        tick;
        tick;
        checks++;
        if (obs !== expv(M_INIT, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_c3_wait: got %b want %b", obs, expv(M_INIT, 1'b0, 1'b0));
        end
        init_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_IDLE, 1'b0, 1'b0)) begin
            errors++; $display("FAIL reset_to_idle: got %b want %b", obs, expv(M_IDLE, 1'b0, 1'b0));
        end
        m_last_rx = 1'b0;
    endtask

    task automatic test_tx_min;
        logic [2:0] seq [5];
        logic       st  [5];
        seq = '{M_TXI, M_TXI, M_TX, M_TX, M_IDLE};
        st  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tx_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (c == 4) tx_req = 1'b0;
            checks++;
            if (obs !== expv(seq[c], st[c], c == 4)) begin
                errors++; $display("FAIL tx_min_c%0d: got %b want %b", c + 1, obs, expv(seq[c], st[c], c == 4));
            end
            if (c == 1 || c == 3) pulse_done(seq[c]);
        end
        tick;
        checks++;
        if (obs !== expv(M_IDLE, 1'b0, 1'b0)) begin
            errors++; $display("FAIL tx_min_ack_once: got %b want %b", obs, expv(M_IDLE, 1'b0, 1'b0));
        end
        m_last_rx = 1'b0;
    endtask

    task automatic test_alternate;
        logic       exp_rx;
        logic [2:0] m0, m1;
        tx_req = 1'b1;
        irq_n  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_rx    = !m_last_rx;
            m_last_rx = exp_rx;
            m0 = exp_rx ? M_RXI : M_TXI;
            m1 = exp_rx ? M_RX  : M_TX;
            tick;
            checks++;
            if (obs !== expv(m0, 1'b1, 1'b0)) begin
                errors++; $display("FAIL alt%0d_first: got %b want %b", i, obs, expv(m0, 1'b1, 1'b0));
            end
            tick; pulse_done(m0);
            tick;
            checks++;
            if (obs !== expv(m1, 1'b1, 1'b0)) begin
                errors++; $display("FAIL alt%0d_main: got %b want %b", i, obs, expv(m1, 1'b1, 1'b0));
            end
            tick; pulse_done(m1);
            tick;
            checks++;
            if (obs !== expv(M_IDLE, 1'b0, !exp_rx)) begin
                errors++; $display("FAIL alt%0d_idle: got %b want %b", i, obs, expv(M_IDLE, 1'b0, !exp_rx));
            end
        end
        tx_req = 1'b0;
        irq_n  = 1'b1;
        tick;
    endtask

    task automatic test_stray;
        irq_n = 1'b0;
        tick;
        irq_n = 1'b1;
        checks++;
        if (obs !== expv(M_RXI, 1'b1, 1'b0)) begin
            errors++; $display("FAIL stray_rxi: got %b want %b", obs, expv(M_RXI, 1'b1, 1'b0));
        end
        rxinit_done = 1'b1;
        tx_done     = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_RXI, 1'b0, 1'b0)) begin
            errors++; $display("FAIL stray_startcycle_done: got %b want %b", obs, expv(M_RXI, 1'b0, 1'b0));
        end
        init_done = 1'b1;
        rx_done   = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_RXI, 1'b0, 1'b0)) begin
            errors++; $display("FAIL stray_foreign_done: got %b want %b", obs, expv(M_RXI, 1'b0, 1'b0));
        end
        rxinit_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_RX, 1'b1, 1'b0)) begin
            errors++; $display("FAIL stray_rx_entry: got %b want %b", obs, expv(M_RX, 1'b1, 1'b0));
        end
        tick; rx_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_IDLE, 1'b0, 1'b0)) begin
            errors++; $display("FAIL stray_rx_idle: got %b want %b", obs, expv(M_IDLE, 1'b0, 1'b0));
        end
        m_last_rx = 1'b1;
    endtask

    task automatic test_random;
        logic        carry_tx, carry_rx, rx, tx, exp_rx;
        logic [2:0]  m, other;
        int unsigned d, s;
        carry_tx = 1'b0;
        carry_rx = 1'b0;
        for (int it = 0; it < 30; it++) begin
            if (!carry_tx && !carry_rx) begin
                d = $urandom_range(0, 2);
                for (int g = 0; g < int'(d); g++) begin
                    tick;
                    checks++;
                    if (obs !== expv(M_IDLE, 1'b0, 1'b0)) begin
                        errors++; $display("FAIL rnd%0d_gap: got %b want %b", it, obs, expv(M_IDLE, 1'b0, 1'b0));
                    end
                end
            end
            rx = carry_rx || ($urandom_range(0, 1) == 1);
            tx = carry_tx || ($urandom_range(0, 1) == 1);
            if (!rx && !tx) rx = 1'b1;
            irq_n  = !rx;
            tx_req = tx;
            exp_rx    = rx && (!tx || !m_last_rx);
            m_last_rx = exp_rx;
            carry_tx  = tx && exp_rx;
            carry_rx  = rx && !exp_rx;
            for (int p = 0; p < 2; p++) begin
                m = exp_rx ? (p == 1 ? M_RX : M_RXI) : (p == 1 ? M_TX : M_TXI);
                d = $urandom_range(1, 4);
                for (int k = 0; k <= int'(d); k++) begin
                    tick;
                    if (p == 0 && k == 0) irq_n = !carry_rx;
                    checks++;
                    if (obs !== expv(m, k == 0, 1'b0)) begin
                        errors++; $display("FAIL rnd%0d_p%0d_k%0d: got %b want %b", it, p, k, obs, expv(m, k == 0, 1'b0));
                    end
                    if (k == int'(d)) begin
                        pulse_done(m);
                    end else if ($urandom_range(0, 1) == 1) begin
                        s = $urandom_range(0, 4);
                        case (s)
                            0:       other = M_INIT;
                            1:       other = M_TXI;
                            2:       other = M_TX;
                            3:       other = M_RXI;
                            default: other = M_RX;
                        endcase
                        if (k == 0 || other != m) pulse_done(other);
                    end
                end
            end
            tick;
            if (!exp_rx) tx_req = carry_tx;
            checks++;
            if (obs !== expv(M_IDLE, 1'b0, !exp_rx)) begin
                errors++; $display("FAIL rnd%0d_done: got %b want %b", it, obs, expv(M_IDLE, 1'b0, !exp_rx));
            end
        end
        tx_req = 1'b0;
        irq_n  = 1'b1;
        tick;
    endtask

    task automatic test_watchdog;
        tx_req = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_TXI, 1'b1, 1'b0)) begin
            errors++; $display("FAIL wd_txi: got %b want %b", obs, expv(M_TXI, 1'b1, 1'b0));
        end
        tick; txinit_done = 1'b1;
        tick;
        checks++;
        if ({obs, err_timeout} !== {expv(M_TX, 1'b1, 1'b0), 1'b0}) begin
            errors++; $display("FAIL wd_tx_entry: got %b want %b", {obs, err_timeout}, {expv(M_TX, 1'b1, 1'b0), 1'b0});
        end
        for (int k = 1; k <= int'(TO) - 1; k++) tick;
        checks++;
        if ({obs, err_timeout} !== {expv(M_TX, 1'b0, 1'b0), 1'b0}) begin
            errors++; $display("FAIL wd_before_expiry: got %b want %b", {obs, err_timeout}, {expv(M_TX, 1'b0, 1'b0), 1'b0});
        end
        tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_INIT, 1'b1, 1'b0), 1'b1, M_TX}) begin
            errors++; $display("FAIL wd_expiry: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_INIT, 1'b1, 1'b0), 1'b1, M_TX});
        end
        tx_req  = 1'b0;
        err_clr = 1'b1;
        tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_INIT, 1'b0, 1'b0), 1'b0, M_TX}) begin
            errors++; $display("FAIL wd_err_clr: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_INIT, 1'b0, 1'b0), 1'b0, M_TX});
        end
        for (int j = 2; j <= int'(TO) - 1; j++) begin
            tick;
            if (j == int'(TO) - 1) err_clr = 1'b1;
        end
        tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_INIT, 1'b1, 1'b0), 1'b1, M_INIT}) begin
            errors++; $display("FAIL wd_init_restart: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_INIT, 1'b1, 1'b0), 1'b1, M_INIT});
        end
        tick; init_done = 1'b1;
        tick;
        err_clr = 1'b1;
        tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_IDLE, 1'b0, 1'b0), 1'b0, M_INIT}) begin
            errors++; $display("FAIL wd_recovered: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_IDLE, 1'b0, 1'b0), 1'b0, M_INIT});
        end
    endtask

    task automatic test_done_vs_expiry;
        irq_n = 1'b0;
        tick;
        irq_n = 1'b1;
        tick; rxinit_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_RX, 1'b1, 1'b0)) begin
            errors++; $display("FAIL dve_rx_entry: got %b want %b", obs, expv(M_RX, 1'b1, 1'b0));
        end
        for (int k = 1; k <= int'(TO) - 1; k++) begin
            tick;
            if (k == 5) tx_done = 1'b1;
            if (k == 6) begin
                checks++;
                if (obs !== expv(M_RX, 1'b0, 1'b0)) begin
                    errors++; $display("FAIL dve_stray_tx_done: got %b want %b", obs, expv(M_RX, 1'b0, 1'b0));
                end
            end
            if (k == int'(TO) - 1) rx_done = 1'b1;
        end
        tick;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_IDLE, 1'b0, 1'b0), 1'b0, M_INIT}) begin
            errors++; $display("FAIL dve_done_wins: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_IDLE, 1'b0, 1'b0), 1'b0, M_INIT});
        end
        m_last_rx = 1'b1;
    endtask

    task automatic test_reset_mid;
        irq_n = 1'b0;
        tick;
        irq_n = 1'b1;
        tick; rxinit_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_RX, 1'b1, 1'b0)) begin
            errors++; $display("FAIL rm_rx_entry: got %b want %b", obs, expv(M_RX, 1'b1, 1'b0));
        end
        tick;
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({obs, err_timeout, err_state} !== {expv(M_INIT, 1'b0, 1'b0), 1'b0, 3'b000}) begin
            errors++; $display("FAIL rm_async: got %b want %b", {obs, err_timeout, err_state},
                               {expv(M_INIT, 1'b0, 1'b0), 1'b0, 3'b000});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            if (i == 0) rx_done = 1'b1;
            checks++;
            if (obs !== expv(M_INIT, 1'b0, 1'b0)) begin
                errors++; $display("FAIL rm_hold%0d: got %b want %b", i, obs, expv(M_INIT, 1'b0, 1'b0));
            end
        end
        reset = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_INIT, 1'b1, 1'b0)) begin
            errors++; $display("FAIL rm_reinit: got %b want %b", obs, expv(M_INIT, 1'b1, 1'b0));
        end
        tick; init_done = 1'b1;
        tick;
        checks++;
        if (obs !== expv(M_IDLE, 1'b0, 1'b0)) begin
            errors++; $display("FAIL rm_idle: got %b want %b", obs, expv(M_IDLE, 1'b0, 1'b0));
        end
        m_last_rx = 1'b0;
    endtask

    initial begin
        test_reset;
        test_tx_min;
        test_alternate;
        test_stray;
        test_random;
        test_watchdog;
        test_done_vs_expiry;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
